// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants: default multiplier width and arbiter state encoding
package fpu_pkg;

    localparam int WIDTH_DEFAULT = 24;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - two-requester request/response bundle for the shared multiplier
interface mul_share_arb_if
    import fpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic [2*WIDTH-1:0]   rsp0_prod;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [2*WIDTH-1:0]   rsp1_prod;

    // Requester side: the FPU operation units.
    modport master (
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_prod,
        input  req1_ready, rsp1_valid, rsp1_prod
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_prod,
        output req1_ready, rsp1_valid, rsp1_prod
    );

endinterface

// File: rtl/mulxbit.sv
// rtl/mulxbit.sv - combinational unsigned WIDTH x WIDTH multiplier, full 2*WIDTH product
module mulxbit #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               done
);

    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Single-cycle implementation; done exists so a pipelined multiplier can drop in later.
    assign done = 1'b1;

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter/sequencer sharing one multiplier between two requesters
module mul_share_arb
    import fpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mul_share_arb_if.slave  bus,
    output logic            busy
);

    logic [1:0]         state;
    logic               rr_ptr;
    logic               owner;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_done;

    logic               gnt_any;
    logic               gnt_id;
    logic               idle_ok;
    logic               fire;
    logic               rsp_accept;

    mulxbit #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a    (op_a),
        .b    (op_b),
        .prod (mul_prod),
        .done (mul_done)
    );

    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        // On contention rr_ptr decides; otherwise whichever requester is valid wins.
        gnt_id  = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
        // rst gates ready so nothing appears accepted while reset is held.
        idle_ok = (state == S_IDLE) & ~rst;
        fire    = idle_ok & gnt_any;
        rsp_accept = owner ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = fire & ~gnt_id;
    assign bus.req1_ready = fire &  gnt_id;
    assign bus.rsp0_valid = (state == S_RESP) & ~owner;
    assign bus.rsp1_valid = (state == S_RESP) &  owner;
    assign bus.rsp0_prod  = bus.rsp0_valid ? prod_q : '0;
    assign bus.rsp1_prod  = bus.rsp1_valid ? prod_q : '0;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= 1'b0;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        op_a   <= gnt_id ? bus.req1_a : bus.req0_a;
                        op_b   <= gnt_id ? bus.req1_b : bus.req0_b;
                        owner  <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (mul_done) begin
                        prod_q <= mul_prod;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_accept) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - directed and randomized self-checking bench for mul_share_arb
module tb_mul_share_arb;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    mul_share_arb_if #(.WIDTH(W)) bus();

    mul_share_arb #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an op is either absent, in its compute cycle, or being offered.
    bit          m_pend  = 1'b0;
    int          m_age   = 0;
    bit          m_owner = 1'b0;
    bit          m_rr    = 1'b0;
    logic [47:0] m_prod  = '0;

    initial begin
        logic        e_r0, e_r1, e_v0, e_v1, e_busy;
        logic [47:0] e_p0, e_p1;
        logic [63:0] full;
        forever begin
            @(negedge clk);
            e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; e_busy = 1'b0;
            e_p0 = '0;   e_p1 = '0;
            if (!rst) begin
                if (!m_pend) begin
                    e_r0 = bus.req0_valid && (!bus.req1_valid || !m_rr);
                    e_r1 = bus.req1_valid && (!bus.req0_valid ||  m_rr);
                end else begin
                    e_busy = 1'b1;
                    if (m_age >= 1) begin
                        e_v0 = !m_owner;
                        e_v1 =  m_owner;
                        e_p0 = e_v0 ? m_prod : '0;
                        e_p1 = e_v1 ? m_prod : '0;
                    end
                end
            end
            chk("cyc_req0_ready", 64'(bus.req0_ready), 64'(e_r0));
            chk("cyc_req1_ready", 64'(bus.req1_ready), 64'(e_r1));
            chk("cyc_rsp0_valid", 64'(bus.rsp0_valid), 64'(e_v0));
            chk("cyc_rsp1_valid", 64'(bus.rsp1_valid), 64'(e_v1));
            chk("cyc_rsp0_prod",  64'(bus.rsp0_prod),  64'(e_p0));
            chk("cyc_rsp1_prod",  64'(bus.rsp1_prod),  64'(e_p1));
            chk("cyc_busy",       64'(busy),           64'(e_busy));
            if (rst) begin
                m_pend = 1'b0;
                m_rr   = 1'b0;
            end else if (!m_pend) begin
                if (e_r0 || e_r1) begin
                    full    = e_r1 ? 64'(bus.req1_a) * 64'(bus.req1_b)
                                   : 64'(bus.req0_a) * 64'(bus.req0_b);
                    m_prod  = full[47:0];
                    m_owner = e_r1;
                    m_rr    = !e_r1;
                    m_pend  = 1'b1;
                    m_age   = 0;
                end
            end else begin
                if (m_age >= 1 && (m_owner ? bus.rsp1_ready : bus.rsp0_ready))
                    m_pend = 1'b0;
                m_age++;
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_samp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        to_drive();
        to_drive();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output bit who, output logic [47:0] p);
        who = 1'b0;
        p   = '0;
        for (int i = 0; i < 30; i++) begin
            to_samp();
            if (bus.rsp0_valid) begin who = 1'b0; p = bus.rsp0_prod; return; end
            if (bus.rsp1_valid) begin who = 1'b1; p = bus.rsp1_prod; return; end
        end
        chk("wait_rsp_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [23:0] rnd_op();
        case ($urandom_range(3))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    bit          who;
    logic [47:0] p;
    int          k, nrec;
    bit          fired;
    bit          rec_own [4];
    logic [47:0] rec_prod[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset();

        // Single request
        bus.req0_valid = 1'b1; bus.req0_a = 24'h000003; bus.req0_b = 24'h000005;
        to_samp();
        chk("t1_req0_ready", 64'(bus.req0_ready), 64'(1));
        to_drive();
        bus.req0_valid = 1'b0;
        to_samp();
        chk("t1_calc_busy", 64'(busy), 64'(1));
        chk("t1_calc_rsp0_valid", 64'(bus.rsp0_valid), 64'(0));
        to_drive();
        to_samp();
        chk("t1_rsp0_valid", 64'(bus.rsp0_valid), 64'(1));
        chk("t1_rsp0_prod", 64'(bus.rsp0_prod), 64'h00000000000F);
        to_drive();
        to_samp();
        chk("t1_idle_busy", 64'(busy), 64'(0));

        // Simultaneous after reset
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 24'hFFFFFF; bus.req0_b = 24'hFFFFFF;
        bus.req1_valid = 1'b1; bus.req1_a = 24'h000002; bus.req1_b = 24'h000003;
        wait_rsp(who, p);
        chk("t2_first_owner", 64'(who), 64'(0));
        chk("t2_first_prod", 64'(p), 64'hFFFFFE000001);
        chk("t2_rsp1_quiet", 64'(bus.rsp1_valid), 64'(0));
        to_drive();
        bus.req0_valid = 1'b0;
        wait_rsp(who, p);
        chk("t2_second_owner", 64'(who), 64'(1));
        chk("t2_second_prod", 64'(p), 64'h000000000006);
        to_drive();
        bus.req1_valid = 1'b0;

        // Backpressure
        bus.req0_valid = 1'b1; bus.req0_a = 24'd7; bus.req0_b = 24'd9; bus.rsp0_ready = 1'b0;
        wait_rsp(who, p);
        for (int i = 0; i < 5; i++) begin
            to_drive();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b1; bus.req1_a = 24'd1; bus.req1_b = 24'd1;
            to_samp();
            chk("t3_hold_valid", 64'(bus.rsp0_valid), 64'(1));
            chk("t3_hold_prod", 64'(bus.rsp0_prod), 64'd63);
            chk("t3_hold_busy", 64'(busy), 64'(1));
            chk("t3_hold_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        end
        to_drive();
        bus.rsp0_ready = 1'b1;
        to_drive();
        to_samp();
        chk("t3_release_busy", 64'(busy), 64'(0));
        chk("t3_release_req1_ready", 64'(bus.req1_ready), 64'(1));
        to_drive();
        bus.req1_valid = 1'b0;
        wait_rsp(who, p);
        chk("t3_req1_prod", 64'(p), 64'd1);

        // Round-robin under continuous contention
        to_drive();
        do_reset();
        k = 1; nrec = 0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_a = 24'(k); bus.req0_b = 24'(k); bus.req1_a = 24'(k); bus.req1_b = 24'(k);
        for (int c = 0; c < 40 && nrec < 4; c++) begin
            to_samp();
            fired = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
            if (bus.rsp0_valid && bus.rsp0_ready) begin rec_own[nrec] = 1'b0; rec_prod[nrec] = bus.rsp0_prod; nrec++; end
            else if (bus.rsp1_valid && bus.rsp1_ready) begin rec_own[nrec] = 1'b1; rec_prod[nrec] = bus.rsp1_prod; nrec++; end
            to_drive();
            if (fired) k++;
            bus.req0_valid = (k <= 4); bus.req1_valid = (k <= 4);
            bus.req0_a = 24'(k); bus.req0_b = 24'(k); bus.req1_a = 24'(k); bus.req1_b = 24'(k);
        end
        chk("t4_count", 64'(nrec), 64'(4));
        if (nrec == 4) begin
            chk("t4_own0", 64'(rec_own[0]), 64'(0)); chk("t4_prod0", 64'(rec_prod[0]), 64'd1);
            chk("t4_own1", 64'(rec_own[1]), 64'(1)); chk("t4_prod1", 64'(rec_prod[1]), 64'd4);
            chk("t4_own2", 64'(rec_own[2]), 64'(0)); chk("t4_prod2", 64'(rec_prod[2]), 64'd9);
            chk("t4_own3", 64'(rec_own[3]), 64'(1)); chk("t4_prod3", 64'(rec_prod[3]), 64'd16);
        end
        idle_inputs();
        repeat (3) to_drive();

        // Reset mid-CALC
        bus.req0_valid = 1'b1; bus.req0_a = 24'd5; bus.req0_b = 24'd5;
        to_samp();
        chk("t5_accept", 64'(bus.req0_ready), 64'(1));
        to_drive();
        bus.req1_valid = 1'b1; bus.req1_a = 24'd6; bus.req1_b = 24'd6;
        chk("t5_in_calc", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        chk("t5_rst_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'(0));
        to_drive();
        rst = 1'b0;
        to_samp();
        chk("t5_post_req0_ready", 64'(bus.req0_ready), 64'(1));
        chk("t5_post_req1_ready", 64'(bus.req1_ready), 64'(0));
        to_drive();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(who, p);
        chk("t5_owner", 64'(who), 64'(0));
        chk("t5_prod", 64'(p), 64'd25);

        // Zero operand
        to_drive();
        bus.req1_valid = 1'b1; bus.req1_a = 24'h000000; bus.req1_b = 24'hABCDEF;
        to_samp();
        to_drive();
        bus.req1_valid = 1'b0;
        wait_rsp(who, p);
        chk("t6_owner", 64'(who), 64'(1));
        chk("t6_prod", 64'(p), 64'h000000000000);

        // Randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            to_drive();
            rst = ($urandom_range(199) == 0);
            bus.req0_valid = ($urandom_range(2) != 0);
            bus.req1_valid = ($urandom_range(2) != 0);
            bus.req0_a = rnd_op(); bus.req0_b = rnd_op();
            bus.req1_a = rnd_op(); bus.req1_b = rnd_op();
            bus.rsp0_ready = ($urandom_range(9) < 7);
            bus.rsp1_ready = ($urandom_range(9) < 7);
        end
        to_drive();
        rst = 1'b0;
        idle_inputs();
        repeat (4) to_drive();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
Two-requester arbiter and sequencer for the shared WIDTH x WIDTH fixed-point multiplier in the FPU.
- Requester 0 is the FP multiply path; requester 1 is the divide/sqrt iteration path.
- Grants one operation at a time, round-robin on contention.
- Registers the operands, captures the product, and holds it until the owning requester accepts it.
- Sits between the FPU operation units and a single multiplier instance.

Parameters:
WIDTH, 24, operand width in bits; the product is 2*WIDTH bits.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
rsp0_valid  out  1  product for requester 0 available
rsp0_ready  in  1  requester 0 consumes product
rsp0_prod  out  2*WIDTH  product for requester 0
req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_prod  same as requester 0, for requester 1
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; rr_ptr=0; owner=0.
  - All operand and product registers=0.
  - reqN_ready=0, rspN_valid=0, busy=0.
  - Outputs take these values immediately, not at the next edge.
- State machine: IDLE -> CALC -> RESP -> IDLE.
- IDLE, grant (combinational):
  - Only reqN_valid high: N is granted.
  - Both high: requester rr_ptr is granted.
  - Granted requester sees reqN_ready=1 in the same cycle; the other sees 0.
  - Transfer occurs when valid&&ready at the edge.
  - At that edge: op_a/op_b are latched, owner is latched, rr_ptr = ~granted id, state goes to CALC.
  - No valid input: stay in IDLE, both ready=0.
- CALC:
  - Multiplier sees registered op_a/op_b.
  - At the edge where the multiplier done=1, the product is captured into prod_q and state goes to RESP.
  - The multiplier is combinational and done is always 1, so CALC lasts exactly 1 cycle.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_prod=prod_q; the other rsp_valid=0.
  - Valid and prod stay stable until rsp[owner]_ready=1; at that edge state goes to IDLE.
  - No new request is accepted in RESP.
- Ready and product gating:
  - reqN_ready=0 in CALC and RESP.
  - rspN_prod reads 0 whenever rspN_valid=0.
- Latency and throughput:
  - Accept at edge k; rsp_valid high in cycle k+2 (after the 2nd edge).
  - Best-case throughput is 1 op per 3 cycles.
- Arithmetic: product = unsigned a*b, full 2*WIDTH bits, no rounding or truncation.
- Boundary conditions:
  - Input changes in CALC/RESP: ignored; operands are registered.
  - reqN_valid dropping before grant: legal, nothing is captured.
  - rsp_ready of the non-owner: ignored.
  - reset during CALC/RESP: operation dropped, no response issued, next contention grants requester 0.

Decomposition:
- Shared package fpu_pkg:
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_RESP=2'd2.
  - default WIDTH constant.
- One sub-module: the existing fixed-point multiplier mulxbit, instanced once with WIDTH passed through.
  - Its done output gates CALC->RESP.
- The arbiter logic stays in mul_share_arb.

Test Plan:
1. Single request: req0 a=0x000003, b=0x000005, rsp0_ready=1 -> req0_ready=1 same cycle; rsp0_valid high 2 edges later; rsp0_prod=0x00000000000F; back to IDLE next edge.
2. Simultaneous after reset: req0 a=b=0xFFFFFF and req1 a=0x000002, b=0x000003 -> req0 granted first with prod=0xFFFFFE000001; req1 granted next with prod=0x000000000006; rsp1_valid=0 during req0's RESP.
3. Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid=1 and prod stable all 5 cycles; busy=1; req0_ready=req1_ready=0; IDLE one edge after rsp0_ready=1.
4. Round-robin: both valid continuously, 4 operations (operand pairs 1x1, 2x2, 3x3, 4x4 per requester) -> owner sequence 0,1,0,1 with matching products.
5. Reset mid-CALC: assert rst in CALC -> busy, rsp valids and readies 0 immediately, no response issued; after release with both valid, requester 0 granted.
6. Zero operand: req1 a=0x000000, b=0xABCDEF -> rsp1_prod=0x000000000000, valid asserted normally.
